// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared types and constants for the BCD converter scheduler: FSM states,
// converter register map and the poll-counter sizing helper.
package bcd_conv_scheduler_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_CLR,
        W_OPA,
        W_GO,
        P_ISS,
        P_CHK,
        W_STOP,
        R_ISS,
        R_CAP,
        DONE_ACK
    } state_t;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_OPA    = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_INIT   = 6'h08;
    localparam logic [ADDR_W-1:0] ADDR_RESULT = 6'h0C;
    localparam logic [ADDR_W-1:0] ADDR_DONE   = 6'h10;

    localparam int unsigned TIMEOUT_POLLS_DEF = 64;

    // Bits needed to hold the value n itself without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// Requester handshake plus converter-peripheral bus, seen from the scheduler
// (master) and from the requesters/peripheral side (slave).
interface bcd_conv_scheduler_if;
    import bcd_conv_scheduler_pkg::*;

    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] bcd_out;
    logic              err;
    logic              busy;

    logic              bus_cs;
    logic              bus_wr;
    logic              bus_rd;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_dout;
    logic [DATA_W-1:0] bus_din;

    modport master (
        input  req0, req1, op0, op1, bus_din,
        output ack0, ack1, bcd_out, err, busy,
        output bus_cs, bus_wr, bus_rd, bus_addr, bus_dout
    );

    modport slave (
        output req0, req1, op0, op1, bus_din,
        input  ack0, ack1, bcd_out, err, busy,
        input  bus_cs, bus_wr, bus_rd, bus_addr, bus_dout
    );

endinterface

// File: rtl/bcd_conv_scheduler_arbiter.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie
// and moves away from whoever was last served when the scheduler says so.
module bcd_rr_arbiter (
    input  logic CLK,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic update_i,
    input  logic last_id_i,
    output logic gnt_vld_o,
    output logic gnt_id_o
);

    logic ptr_q;
    logic ptr_d;

    always_ff @(posedge CLK) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = ~last_id_i;
        end
    end

    assign gnt_vld_o = req0_i | req1_i;
    assign gnt_id_o  = (req0_i & req1_i) ? ptr_q : req1_i;

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Serialises binary-to-BCD conversions from two requesters onto one converter
// peripheral: program operand, start, poll DONE with timeout, read result, ack.
module bcd_conv_scheduler
    import bcd_conv_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT_POLLS = TIMEOUT_POLLS_DEF
) (
    input  logic                 CLK,
    input  logic                 reset,
    bcd_conv_scheduler_if.master conv_io
);

    localparam int unsigned        CNT_W    = cnt_width(TIMEOUT_POLLS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_POLLS - 1);

    state_t            state_q, state_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic [DATA_W-1:0] bcd_q, bcd_d;

    logic              gnt_vld;
    logic              gnt_id;

    logic              cs, wr, rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              ack0, ack1, err;

    bcd_rr_arbiter u_arb (
        .CLK       (CLK),
        .reset     (reset),
        .req0_i    (conv_io.req0),
        .req1_i    (conv_io.req1),
        .update_i  (state_q == DONE_ACK),
        .last_id_i (id_q),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            op_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            bcd_q   <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    id_d    = gnt_id;
                    op_d    = gnt_id ? conv_io.op1 : conv_io.op0;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = W_CLR;
                end
            end
            W_CLR:  state_d = W_OPA;
            W_OPA:  state_d = W_GO;
            W_GO:   state_d = P_ISS;
            P_ISS:  state_d = P_CHK;
            P_CHK: begin
                if (conv_io.bus_din[0]) begin
                    state_d = W_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = W_STOP;
                    end else begin
                        state_d = P_ISS;
                    end
                end
            end
            // A timed-out conversion never reads RESULT, so bcd_out keeps its old value.
            W_STOP: state_d = tmo_q ? DONE_ACK : R_ISS;
            R_ISS:  state_d = R_CAP;
            R_CAP: begin
                bcd_d   = conv_io.bus_din;
                state_d = DONE_ACK;
            end
            DONE_ACK: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cs   = 1'b0;
        wr   = 1'b0;
        rd   = 1'b0;
        addr = '0;
        dout = '0;
        ack0 = 1'b0;
        ack1 = 1'b0;
        err  = 1'b0;
        case (state_q)
            W_CLR, W_STOP: begin
                cs   = 1'b1;
                wr   = 1'b1;
                addr = ADDR_INIT;
            end
            W_OPA: begin
                cs   = 1'b1;
                wr   = 1'b1;
                addr = ADDR_OPA;
                dout = op_q;
            end
            W_GO: begin
                cs   = 1'b1;
                wr   = 1'b1;
                addr = ADDR_INIT;
                dout = 16'h0001;
            end
            P_ISS: begin
                cs   = 1'b1;
                rd   = 1'b1;
                addr = ADDR_DONE;
            end
            R_ISS: begin
                cs   = 1'b1;
                rd   = 1'b1;
                addr = ADDR_RESULT;
            end
            DONE_ACK: begin
                ack0 = ~id_q;
                ack1 = id_q;
                err  = tmo_q;
            end
            default: begin
            end
        endcase
    end

    assign conv_io.bus_cs   = cs;
    assign conv_io.bus_wr   = wr;
    assign conv_io.bus_rd   = rd;
    assign conv_io.bus_addr = addr;
    assign conv_io.bus_dout = dout;
    assign conv_io.ack0     = ack0;
    assign conv_io.ack1     = ack1;
    assign conv_io.err      = err;
    assign conv_io.busy     = (state_q != IDLE);
    assign conv_io.bcd_out  = bcd_q;

endmodule
